relay_bank_timed: RTL and testbench
===================================

# relay_bank_timed

Parametrised, clocked bank of electromechanical relay models for the 1620 typewriter and I/O control logic. Each relay is individually configured as a duo relay (pick + hold coils) or a latching relay (pick + trip coils). Each relay has finite operate and release times, counted in `tick` strobes, and break-before-make transfer contacts. An optional CRCB-style cam timer supplies angle-windowed cam contacts. The block replaces the zero-delay, level-evaluated relay stanzas in the control-logic modules.

## Interface

Parameters:
- `N_RELAYS`, 16: number of relays in the bank.
- `LATCH_MASK`, 0: bit i = 1 makes relay i latching; bit i = 0 makes it duo.
- `PICK_TICKS`, 3: operate time in ticks. Legal range 1..15.
- `DROP_TICKS`, 2: release time in ticks. Legal range 1..15.
- `CAM_N`, 6: number of cam contacts. Used only with `RELAY_BANK_CAM_EN`.
- `CAM_ON`, packed `CAM_N`×9 bits: per-cam close angle in degrees.
- `CAM_OFF`, packed `CAM_N`×9 bits: per-cam open angle in degrees (exclusive).

Ports:
- `clk`, input, 1: single system clock.
- `rst_n`, input, 1: reset. **Synchronous, active-low.**
- `tick`, input, 1: one-cycle mechanical time-base strobe. All relay and cam motion advances only on cycles where `tick` = 1.
- `pick_coil`, input, `N_RELAYS`: pick coil energised, per relay.
- `hold_coil`, input, `N_RELAYS`: hold coil for duo relays; trip coil for latching relays.
- `contact_no`, output, `N_RELAYS`: normally-open contact closed.
- `contact_nc`, output, `N_RELAYS`: normally-closed contact closed.
- `in_transit`, output, `N_RELAYS`: armature is moving (PICKING or DROPPING).
- `cam_run`, input, 1: cam clutch engaged.
- `cam_angle`, output, 9: current cam angle, 0..359.
- `cam_no`, output, `CAM_N`: cam contacts closed.

## Operation

Each relay runs its own FSM with states OPEN, PICKING, CLOSED, DROPPING and a 4-bit counter. The FSM evaluates only on `tick` cycles.

Energise condition:
- Duo relay, OPEN: `pick_coil` only. The hold coil alone never operates an open relay.
- Duo relay, all other states: `pick_coil | hold_coil`.
- Latching relay: a set request is `pick_coil`; a release request is `hold_coil & ~pick_coil`. Pick dominates trip.

Transitions:
- OPEN → PICKING when the energise condition (duo) or a set request (latching) is present. Counter loads `PICK_TICKS-1`.
- PICKING, counter = 0 → CLOSED.
- PICKING, duo relay de-energised before completion → OPEN on that tick, with no DROPPING phase. A latching relay cannot abort once PICKING.
- CLOSED → DROPPING when a duo relay is de-energised or a latching relay sees a release request. Counter loads `DROP_TICKS-1`.
- DROPPING, counter = 0 → OPEN.
- DROPPING, re-energised (duo) or set request (latching) → PICKING, counter reloaded.
- Counter decrements on each tick while PICKING or DROPPING.

Outputs per state (registered):
- OPEN: `contact_nc` = 1, `contact_no` = 0.
- CLOSED: `contact_no` = 1, `contact_nc` = 0.
- PICKING and DROPPING: both contacts 0 (break-before-make), `in_transit` = 1.

Cam:
- `cam_angle` increments by 1 on each tick while `cam_run` = 1. It wraps from 359 to 0. It holds its value when `cam_run` = 0.
- Cam j is closed when `CAM_ON[j] <= angle < CAM_OFF[j]`.
- If `CAM_ON[j] > CAM_OFF[j]`, the window wraps: closed when `angle >= ON` or `angle < OFF`.
- If `CAM_ON[j] == CAM_OFF[j]`, cam j never closes.

## Timing

- Reset: all relays OPEN, counters 0, `contact_nc` = all 1, `contact_no` = 0, `in_transit` = 0, `cam_angle` = 0, `cam_no` = the window decode at angle 0. Reset has priority over `tick`.
- Reset mid-transit aborts immediately to OPEN.
- Pick latency: with coil asserted on tick k, `contact_nc` falls at the clock edge of tick k and `contact_no` rises at the edge of tick k+`PICK_TICKS`. Release is symmetric using `DROP_TICKS`.
- Coil changes between ticks are ignored. Only the coil value sampled on the tick cycle counts.
- `cam_no` is decoded combinationally from the registered `cam_angle`.

## Configuration

- `RELAY_BANK_CAM_EN` defined: the cam angle counter and window decoders are built.
- Not defined: ports remain, `cam_angle` is tied to 0, `cam_no` is tied to 0, `cam_run` is ignored, and no cam logic is synthesised.

## Structure

- Package `relay_pkg` holds:
  - enum `relay_state_t` (OPEN, PICKING, CLOSED, DROPPING);
  - `ANGLE_W` = 9;
  - `ANGLE_MAX` = 359;
  - `TCNT_W` = 4.
- Sub-module `relay_cell` contains one FSM plus its counter, with parameters `LATCHING`, `PICK_TICKS`, `DROP_TICKS`. It is instantiated `N_RELAYS` times by a generate loop.
- Cam logic is written inline, inside `` `ifdef ``.

## Test plan

- Duo relay, `PICK_TICKS`=3, `pick_coil` held: NC drops on tick 1, NO rises on tick 4, `in_transit` is high on ticks 1–3.
- Duo relay: `hold_coil` alone from OPEN → stays OPEN. Pick, then release pick while hold is held → stays CLOSED. Drop hold → NO falls at once and NC rises 2 ticks later.
- Latching relay: one-tick pick → CLOSED after 3 ticks, then stays closed with no coil. Trip → OPEN after 2 ticks. Pick and trip together → remains or becomes CLOSED.
- Abort cases: duo pick removed after 1 tick → OPEN on the next tick with NC restored. Re-energise during DROPPING → PICKING, and NO returns 3 ticks later.
- Cam, with `CAM_ON`=310 and `CAM_OFF`=360, plus a wrap window ON=350, OFF=10: run 400 ticks → `cam_angle` wraps 359→0. Cam 0 is closed at 310–359; the wrap cam is closed at 350–359 and 0–9. `cam_run` low freezes the angle.
- `rst_n` low for one cycle mid-PICKING and at angle 200 → all relays OPEN and `cam_angle` = 0 on the next edge. Repeat the build without `RELAY_BANK_CAM_EN` → `cam_no` and `cam_angle` stay 0.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and constants for the timed relay bank.
package relay_pkg;

  localparam int ANGLE_W   = 9;
  localparam int ANGLE_MAX = 359;
  localparam int TCNT_W    = 4;

  typedef enum logic [1:0] {
    OPEN     = 2'd0,
    PICKING  = 2'd1,
    CLOSED   = 2'd2,
    DROPPING = 2'd3
  } relay_state_t;

  // Cam window decode: ON <= a < OFF, wrapping when ON > OFF, never when equal.
  function automatic logic cam_win(input logic [ANGLE_W-1:0] a,
                                   input logic [ANGLE_W-1:0] on,
                                   input logic [ANGLE_W-1:0] off);
    if (on == off) return 1'b0;
    if (on < off)  return (a >= on) && (a < off);
    return (a >= on) || (a < off);
  endfunction

endpackage

// File: rtl/relay_cell.sv
// One relay: OPEN/PICKING/CLOSED/DROPPING FSM with operate/release counter.
// Duo (pick + hold) or latching (pick + trip) selected by LATCHING.
module relay_cell
  import relay_pkg::*;
#(
  parameter bit LATCHING   = 1'b0,
  parameter int PICK_TICKS = 3,
  parameter int DROP_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pick,
  input  logic hold,
  output logic contact_no,
  output logic contact_nc,
  output logic in_transit
);

  localparam logic [TCNT_W-1:0] PICK_LD = TCNT_W'(PICK_TICKS - 1);
  localparam logic [TCNT_W-1:0] DROP_LD = TCNT_W'(DROP_TICKS - 1);

  relay_state_t      state_q, state_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic              no_q, no_d, nc_q, nc_d, tr_q, tr_d;
  logic              set_req, rel_req;

  // Next-state: coils only count on tick cycles; duo hold only sustains, never operates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (LATCHING) begin
      set_req = pick;
      rel_req = hold & ~pick;
    end else begin
      set_req = (state_q == OPEN) ? pick : (pick | hold);
      rel_req = ~set_req;
    end
    if (tick) begin
      unique case (state_q)
        OPEN: if (set_req) begin
          state_d = PICKING;
          cnt_d   = PICK_LD;
        end
        PICKING: begin
          if (!LATCHING && rel_req) begin
            state_d = OPEN;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = CLOSED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        CLOSED: if (rel_req) begin
          state_d = DROPPING;
          cnt_d   = DROP_LD;
        end
        DROPPING: begin
          if (set_req) begin
            state_d = PICKING;
            cnt_d   = PICK_LD;
          end else if (cnt_q == '0) begin
            state_d = OPEN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = OPEN;
          cnt_d   = '0;
        end
      endcase
    end
    no_d = (state_d == CLOSED);
    nc_d = (state_d == OPEN);
    tr_d = (state_d == PICKING) || (state_d == DROPPING);
  end

  // State, counter and registered contact outputs; reset wins over tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OPEN;
      cnt_q   <= '0;
      no_q    <= 1'b0;
      nc_q    <= 1'b1;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      no_q    <= no_d;
      nc_q    <= nc_d;
      tr_q    <= tr_d;
    end
  end

  assign contact_no = no_q;
  assign contact_nc = nc_q;
  assign in_transit = tr_q;

endmodule

// File: rtl/relay_bank_timed.sv
// Bank of timed relay models plus optional cam timer.
// Cam timer is built only when RELAY_BANK_CAM_EN is defined.
module relay_bank_timed
  import relay_pkg::*;
#(
  parameter int                          N_RELAYS   = 16,
  parameter logic [N_RELAYS-1:0]         LATCH_MASK = '0,
  parameter int                          PICK_TICKS = 3,
  parameter int                          DROP_TICKS = 2,
  parameter int                          CAM_N      = 6,
  parameter logic [CAM_N*ANGLE_W-1:0]    CAM_ON     = {9'd300, 9'd240, 9'd180, 9'd120, 9'd60, 9'd0},
  parameter logic [CAM_N*ANGLE_W-1:0]    CAM_OFF    = {9'd330, 9'd270, 9'd210, 9'd150, 9'd90, 9'd30}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [N_RELAYS-1:0] pick_coil,
  input  logic [N_RELAYS-1:0] hold_coil,
  output logic [N_RELAYS-1:0] contact_no,
  output logic [N_RELAYS-1:0] contact_nc,
  output logic [N_RELAYS-1:0] in_transit,
  input  logic                cam_run,
  output logic [ANGLE_W-1:0]  cam_angle,
  output logic [CAM_N-1:0]    cam_no
);

  for (genvar i = 0; i < N_RELAYS; i++) begin : g_relay
    relay_cell #(
      .LATCHING   (LATCH_MASK[i]),
      .PICK_TICKS (PICK_TICKS),
      .DROP_TICKS (DROP_TICKS)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .pick       (pick_coil[i]),
      .hold       (hold_coil[i]),
      .contact_no (contact_no[i]),
      .contact_nc (contact_nc[i]),
      .in_transit (in_transit[i])
    );
  end

`ifdef RELAY_BANK_CAM_EN
  logic [ANGLE_W-1:0] angle_q, angle_d;

  // Cam shaft advances one degree per tick while the clutch is engaged.
  always_comb begin
    angle_d = angle_q;
    if (tick && cam_run)
      angle_d = (angle_q == ANGLE_W'(ANGLE_MAX)) ? '0 : angle_q + 1'b1;
  end

  // Cam angle register.
  always_ff @(posedge clk) begin
    if (!rst_n) angle_q <= '0;
    else        angle_q <= angle_d;
  end

  assign cam_angle = angle_q;

  // Per-cam window decode from the registered angle.
  always_comb begin
    cam_no = '0;
    for (int j = 0; j < CAM_N; j++)
      cam_no[j] = cam_win(angle_q, CAM_ON[j*ANGLE_W +: ANGLE_W], CAM_OFF[j*ANGLE_W +: ANGLE_W]);
  end
`else
  logic unused_cam;
  assign unused_cam = ^{cam_run, CAM_ON, CAM_OFF};
  assign cam_angle  = '0;
  assign cam_no     = '0;
`endif

endmodule

// File: tb/tb_relay_bank_timed.sv
// Directed bench for relay_bank_timed: 4 relays (relay 2 latching), 2 cams.
module tb_relay_bank_timed;

  localparam int N = 4;
  localparam int CN = 2;
`ifdef RELAY_BANK_CAM_EN
  localparam logic [CN-1:0] CAM_AT0 = 2'b10;
`else
  localparam logic [CN-1:0] CAM_AT0 = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_n, tick, cam_run;
  logic [N-1:0]  pick_coil, hold_coil, contact_no, contact_nc, in_transit;
  logic [8:0]    cam_angle;
  logic [CN-1:0] cam_no;

  int errs = 0;
  int checks = 0;

  relay_bank_timed #(
    .N_RELAYS   (N),
    .LATCH_MASK (4'b0100),
    .PICK_TICKS (3),
    .DROP_TICKS (2),
    .CAM_N      (CN),
    .CAM_ON     ({9'd350, 9'd310}),
    .CAM_OFF    ({9'd10, 9'd360})
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .pick_coil  (pick_coil),
    .hold_coil  (hold_coil),
    .contact_no (contact_no),
    .contact_nc (contact_nc),
    .in_transit (in_transit),
    .cam_run    (cam_run),
    .cam_angle  (cam_angle),
    .cam_no     (cam_no)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tick strobe covering exactly one posedge; returns at the next negedge.
  task automatic tk();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  logic [8:0]    ea;
  logic [CN-1:0] ec;

  initial begin
    rst_n = 1'b0; tick = 1'b0; cam_run = 1'b0;
    pick_coil = '0; hold_coil = '0;
    idle(); idle();
    chk("rst nc", contact_nc, 4'hF);
    chk("rst no", contact_no, 4'h0);
    chk("rst tr", in_transit, 4'h0);
    chk("rst angle", cam_angle, 0);
    chk("rst cam", cam_no, CAM_AT0);
    rst_n = 1'b1;
    idle();

    // Duo pick, operate time 3
    pick_coil[0] = 1'b1;
    tk();
    chk("pk1 nc", contact_nc[0], 0);
    chk("pk1 tr", in_transit[0], 1);
    chk("pk1 no", contact_no[0], 0);
    tk(); tk();
    chk("pk3 tr", in_transit[0], 1);
    chk("pk3 no", contact_no[0], 0);
    tk();
    chk("pk4 no", contact_no[0], 1);
    chk("pk4 nc", contact_nc[0], 0);
    chk("pk4 tr", in_transit[0], 0);

    // Coil glitch between ticks is ignored
    pick_coil[0] = 1'b0; idle();
    pick_coil[0] = 1'b1; idle();
    chk("glitch no", contact_no[0], 1);

    // Hold sustains a closed duo relay; dropping hold releases
    hold_coil[0] = 1'b1; pick_coil[0] = 1'b0;
    tk(); tk();
    chk("hold keeps", contact_no[0], 1);
    hold_coil[0] = 1'b0;
    tk();
    chk("drop1 no", contact_no[0], 0);
    chk("drop1 nc", contact_nc[0], 0);
    chk("drop1 tr", in_transit[0], 1);
    tk();
    chk("drop2 nc", contact_nc[0], 0);
    tk();
    chk("drop3 nc", contact_nc[0], 1);
    chk("drop3 tr", in_transit[0], 0);

    // Hold alone never operates an open duo relay
    hold_coil[1] = 1'b1;
    tk(); tk();
    chk("holdonly no", contact_no[1], 0);
    chk("holdonly nc", contact_nc[1], 1);
    chk("holdonly tr", in_transit[1], 0);
    hold_coil[1] = 1'b0;

    // Latching: one-tick pick, trip during picking cannot abort
    pick_coil[2] = 1'b1;
    tk();
    pick_coil[2] = 1'b0; hold_coil[2] = 1'b1;
    chk("lat pk tr", in_transit[2], 1);
    tk();
    hold_coil[2] = 1'b0;
    tk();
    chk("lat pk3 no", contact_no[2], 0);
    tk();
    chk("lat closed", contact_no[2], 1);
    tk(); tk();
    chk("lat stays", contact_no[2], 1);
    hold_coil[2] = 1'b1;
    tk();
    hold_coil[2] = 1'b0;
    chk("trip tr", in_transit[2], 1);
    chk("trip no", contact_no[2], 0);
    tk();
    chk("trip2 nc", contact_nc[2], 0);
    tk();
    chk("trip3 nc", contact_nc[2], 1);

    // Latching: pick and trip together, pick dominates
    pick_coil[2] = 1'b1; hold_coil[2] = 1'b1;
    tk();
    chk("both tr", in_transit[2], 1);
    tk(); tk(); tk();
    chk("both closed", contact_no[2], 1);
    tk();
    chk("both stays", contact_no[2], 1);
    pick_coil[2] = 1'b0; hold_coil[2] = 1'b0;

    // Duo abort during picking
    pick_coil[1] = 1'b1;
    tk();
    chk("abort tr", in_transit[1], 1);
    chk("abort nc0", contact_nc[1], 0);
    pick_coil[1] = 1'b0;
    tk();
    chk("abort nc", contact_nc[1], 1);
    chk("abort tr0", in_transit[1], 0);

    // Re-energise during dropping
    pick_coil[0] = 1'b1;
    tk(); tk(); tk(); tk();
    chk("re closed", contact_no[0], 1);
    pick_coil[0] = 1'b0;
    tk();
    chk("re dropping", in_transit[0], 1);
    pick_coil[0] = 1'b1;
    tk();
    chk("re picking tr", in_transit[0], 1);
    chk("re picking no", contact_no[0], 0);
    tk(); tk();
    chk("re pk3 no", contact_no[0], 0);
    tk();
    chk("re no back", contact_no[0], 1);

    // Reset mid-picking (also with a tick pending) opens everything, latching too
    pick_coil[1] = 1'b1;
    tk();
    chk("pre-rst tr", in_transit[1], 1);
    pick_coil = '0; hold_coil = '0;
    rst_n = 1'b0; tick = 1'b1;
    idle();
    rst_n = 1'b1; tick = 1'b0;
    chk("mid rst nc", contact_nc, 4'hF);
    chk("mid rst no", contact_no, 4'h0);
    chk("mid rst tr", in_transit, 4'h0);
    tk();
    chk("post rst nc", contact_nc, 4'hF);

`ifdef RELAY_BANK_CAM_EN
    // Cam run through wrap with window model
    ea = '0;
    cam_run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tk();
      ea = (ea == 9'd359) ? 9'd0 : ea + 9'd1;
      ec = {((ea >= 9'd350) || (ea < 9'd10)), (ea >= 9'd310)};
      chk("cam angle", cam_angle, ea);
      chk("cam no", cam_no, ec);
    end
    cam_run = 1'b0;
    tk(); tk(); tk();
    chk("cam freeze", cam_angle, ea);
    cam_run = 1'b1;
    while (ea != 9'd200) begin
      tk();
      ea = ea + 9'd1;
    end
    chk("cam at200", cam_angle, 200);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("cam rst angle", cam_angle, 0);
    chk("cam rst no", cam_no, CAM_AT0);
`else
    // Without the cam timer, outputs stay tied low
    cam_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tk();
      chk("nocam angle", cam_angle, 0);
      chk("nocam no", cam_no, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
